// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed requests into word-indexed memory
// strobes, doing read-modify-write for sub-word stores and extending loads.
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic        mem_memWrite,
   output logic        mem_memRead,
   input  logic [31:0] mem_readData
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;
   logic [1:0]  size_q;
   logic        write_q, uns_q;
   logic        accept, req_illegal;

   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_val, merge_val;

   assign accept      = (state_q == IDLE) && req_valid;
   assign req_illegal = (req_size == 2'b11)
                      | ((req_size == SZ_H) & req_addr[0])
                      | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));

   // Word stores take their data straight from the request, so only the
   // low halfword has to be kept for the merge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata[15:0];
         size_q  <= req_size;
         write_q <= req_write;
         uns_q   <= req_unsigned;
      end
   end

   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_sel = mem_readData[7:0];
         2'd1:    byte_sel = mem_readData[15:8];
         2'd2:    byte_sel = mem_readData[23:16];
         default: byte_sel = mem_readData[31:24];
      endcase
      half_sel = addr_q[1] ? mem_readData[31:16] : mem_readData[15:0];
      case (size_q)
         SZ_B:    load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
         SZ_H:    load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
         default: load_val = mem_readData;
      endcase
   end

   always_comb begin
      merge_val = mem_readData;
      if (size_q == SZ_B)
         merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else
         merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q;
   end

   // Memory strobes are computed one state ahead so they come out of flops.
   always_comb begin
      state_d     = state_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      rdata_d     = rdata_q;
      error_d     = error_q;
      case (state_q)
         IDLE: if (req_valid) begin
            rdata_d = '0;
            error_d = req_illegal;
            if (req_illegal) begin
               state_d = RESP;
            end else if (req_write && (req_size == SZ_W)) begin
               state_d     = WR;
               mem_write_d = 1'b1;
               mem_addr_d  = {2'b00, req_addr[31:2]};
               mem_wdata_d = req_wdata;
            end else begin
               state_d    = RD;
               mem_read_d = 1'b1;
               mem_addr_d = {2'b00, req_addr[31:2]};
            end
         end
         RD: if (write_q) begin
            state_d     = WR;
            mem_write_d = 1'b1;
            mem_addr_d  = {2'b00, addr_q[31:2]};
            mem_wdata_d = merge_val;
         end else begin
            state_d = RESP;
            rdata_d = load_val;
         end
         WR: state_d = RESP;
         RESP: if (resp_ready) begin
            state_d = IDLE;
            rdata_d = '0;
            error_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         error_q     <= error_d;
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign resp_valid    = (state_q == RESP);
   assign resp_rdata    = rdata_q;
   assign resp_error    = error_q;
   assign mem_address   = mem_addr_q;
   assign mem_writeData = mem_wdata_q;
   assign mem_memWrite  = mem_write_q;
   assign mem_memRead   = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural memory, reference memory model and
// an expected-response queue checked as each completion appears.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_error;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address, mem_writeData, mem_readData;
   logic        mem_memWrite, mem_memRead;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      logic [31:0] waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem[64];
   logic [31:0] ref_mem[64];
   logic        inited = 1'b0;
   int          n_rd = 0, n_wr = 0;
   logic [31:0] last_waddr = '0, last_wdata = '0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mem_address(mem_address), .mem_writeData(mem_writeData),
      .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
      .mem_readData(mem_readData)
   );

   function automatic logic [31:0] init_word(int i);
      return 32'h1357_9BDF ^ (i * 32'h9E37_79B1);
   endfunction

   assign mem_readData = mem_memRead ? mem[mem_address[5:0]] : 32'h0;

   always @(posedge clk) begin
      if (!inited) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
         inited <= 1'b1;
      end else if (mem_memWrite) begin
         mem[mem_address[5:0]] <= mem_writeData;
      end
   end

   always @(negedge clk) begin
      if (mem_memRead) n_rd <= n_rd + 1;
      if (mem_memWrite) begin
         n_wr       <= n_wr + 1;
         last_waddr <= mem_address;
         last_wdata <= mem_writeData;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mdl_load(logic [31:0] w, logic [1:0] sz, logic u, logic [1:0] a);
      logic [31:0] s;
      if (sz == 2'b00) begin
         s = w >> (a * 8);
         return u ? (s & 32'hFF) : ((s & 32'hFF) | (s[7] ? 32'hFFFF_FF00 : 32'h0));
      end else if (sz == 2'b01) begin
         s = w >> (a[1] * 16);
         return u ? (s & 32'hFFFF) : ((s & 32'hFFFF) | (s[15] ? 32'hFFFF_0000 : 32'h0));
      end
      return w;
   endfunction

   function automatic logic [31:0] mdl_merge(logic [31:0] w, logic [1:0] sz, logic [1:0] a, logic [31:0] wd);
      logic [31:0] m;
      int          sh;
      m  = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
      sh = (sz == 2'b00) ? a * 8 : a[1] * 16;
      return (w & ~(m << sh)) | ((wd & m) << sh);
   endfunction

   task automatic run_req(input logic wr, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
      exp_t        e;
      int          lat, rd0, wr0;
      logic [31:0] w;
      @(negedge clk);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      w = ref_mem[a[7:2]];
      e.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      e.rdata = '0;
      e.nrd   = 0;
      e.nwr   = 0;
      e.waddr = {2'b00, a[31:2]};
      e.wdata = '0;
      if (e.err) begin
         e.lat = 1;
      end else if (!wr) begin
         e.lat = 2; e.nrd = 1;
         e.rdata = mdl_load(w, sz, u, a[1:0]);
      end else if (sz == 2'b10) begin
         e.lat = 2; e.nwr = 1; e.wdata = wd;
         ref_mem[a[7:2]] = wd;
      end else begin
         e.lat = 3; e.nrd = 1; e.nwr = 1;
         e.wdata = mdl_merge(w, sz, a[1:0], wd);
         ref_mem[a[7:2]] = e.wdata;
      end
      sb.push_back(e);
      rd0 = n_rd; wr0 = n_wr;
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd; resp_ready = (hold == 0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 10);
      e = sb.pop_front();
      chk("resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("latency", lat, e.lat);
      chk("resp_rdata", resp_rdata, e.rdata);
      chk("resp_error", {31'b0, resp_error}, {31'b0, e.err});
      chk("n_read", n_rd - rd0, e.nrd);
      chk("n_write", n_wr - wr0, e.nwr);
      if (e.nwr != 0) begin
         chk("write_addr", last_waddr, e.waddr);
         chk("write_data", last_wdata, e.wdata);
      end
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
         req_addr = 32'h20; req_wdata = 32'h0BAD_0BAD;
         @(negedge clk);
         chk("bp_valid", {31'b0, resp_valid}, 32'd1);
         chk("bp_rdata", resp_rdata, e.rdata);
         chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      end
      if (hold > 0) begin
         req_valid = 1'b0; resp_ready = 1'b1;
         @(negedge clk);
         chk("bp_rel_valid", {31'b0, resp_valid}, 32'd0);
         chk("bp_rel_ready", {31'b0, req_ready}, 32'd1);
         chk("bp_no_write", n_wr - wr0, e.nwr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_strobes", {30'b0, mem_memRead, mem_memWrite}, 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_mem_wdata", mem_writeData, 32'd0);
      rst_n = 1'b1;

      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);

      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 0);
      run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FFAA, 0);
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);

      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80F0_7F01, 0);
      run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0);
      run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
      run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
      run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
      run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
      run_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_ABCD, 0);
      run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0);

      run_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 0);
      run_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h5555, 0);
      run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);

      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
      run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);

      // Byte store interrupted by reset while reading.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
      req_addr = 32'h11; req_wdata = 32'h55;
      @(posedge clk);
      #1 req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("rst_rd_memRead", {31'b0, mem_memRead}, 32'd0);
      chk("rst_rd_memWrite", {31'b0, mem_memWrite}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rd_word", mem[4], ref_mem[4]);
      chk("rst_rd_resp", {31'b0, resp_valid}, 32'd0);
      chk("rst_rd_ready", {31'b0, req_ready}, 32'd1);

      // Word store interrupted by reset while writing.
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
      req_addr = 32'h10; req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      chk("wr_strobe_up", {31'b0, mem_memWrite}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_wr_memWrite", {31'b0, mem_memWrite}, 32'd0);
      chk("rst_wr_address", mem_address, 32'd0);
      chk("rst_wr_wdata", mem_writeData, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_wr_word", mem[4], ref_mem[4]);
      chk("rst_wr_resp", {31'b0, resp_valid}, 32'd0);
      chk("rst_wr_ready", {31'b0, req_ready}, 32'd1);
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);

      for (int i = 0; i < 40; i++) begin
         run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                 $urandom, 0);
      end
      for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. Accepts one byte-addressed load/store request at a time from the datapath and converts it into word-indexed read/write strobes toward the data memory. Byte and halfword stores are done as read-modify-write. Load results are aligned, then sign- or zero-extended. Sits between the MEM stage and the data memory; returns each completion over a valid/ready response channel.

## Interface
- No parameters. Data and address width is fixed at 32 bits; the memory is indexed in 32-bit words.
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a request is presented.
- req_ready  out  1  the unit can accept a request; equals (state == IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  a completion is presented.
- resp_ready  in  1  consumer accepts the completion.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request.
- mem_address  out  32  word index, {2'b00, addr[31:2]}.
- mem_writeData  out  32  full word to write.
- mem_memWrite  out  1  write strobe.
- mem_memRead  out  1  read enable.
- mem_readData  in  32  memory read word; combinational from mem_address while mem_memRead = 1.

## Operation
- States: IDLE, RD, WR, RESP. Reset state: IDLE.
- **IDLE:** on req_valid, capture addr, size, write, unsigned and wdata into registers. Next state:
  - RESP with error set, if the request is illegal: size = 11; halfword with addr[0] = 1; or word with addr[1:0] ≠ 0.
  - RD for any load.
  - WR for a word store.
  - RD for a byte or halfword store.
- **RD:**
  - Outputs: mem_memRead = 1, mem_address = captured word index.
  - At the clock edge, register mem_readData.
  - Load: next state RESP, with resp_rdata = extracted lane, extended per req_unsigned.
  - Store: merge the new data into the read word, then next state WR.
- **WR:**
  - Outputs: mem_memWrite = 1, mem_address = captured word index, mem_writeData = merged or full word.
  - mem_memRead = 0 in this state.
  - Next state RESP.
- **RESP:** resp_valid = 1, resp_rdata/resp_error held stable. On resp_ready, next state IDLE. The response is held for as many cycles as resp_ready stays 0.
- Lane selection (little-endian):
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword h = addr[1] occupies bits [16h+15:16h].
- Merge: replace only the selected lane with the low bits of wdata; all other bits come from the read word.
- Sign extension: replicate bit 7 (byte) or bit 15 (halfword) into the upper bits.
- Outside RD/WR:
  - mem_memRead = mem_memWrite = 0.
  - mem_address = 0, mem_writeData = 0.
  - All mem_* outputs are driven from registers (glitch-free).
- An error request never asserts mem_memRead or mem_memWrite.
- req_valid while state ≠ IDLE is ignored; the request is not captured.

## Timing
- Request accepted at edge E0 (req_valid & req_ready).
- resp_valid first goes high:
  - error: after E1 (1 cycle);
  - load or word store: after E2 (2 cycles);
  - byte/halfword store: after E3 (3 cycles).
- Back-to-back throughput: resp_valid & resp_ready at edge En returns the unit to IDLE, so req_ready = 1 in the following cycle. The minimum gap between acceptances is latency + 1 cycles.
- mem_memWrite is high for exactly one cycle per store. mem_address and mem_writeData are stable for that whole cycle and are cleared on the same edge that drops mem_memWrite.
- Reset values while rst_n is low (asynchronous):
  - req_ready = 1;
  - resp_valid = 0, resp_error = 0, resp_rdata = 0;
  - mem_memRead = 0, mem_memWrite = 0, mem_address = 0, mem_writeData = 0.
- Reset mid-operation (RD, WR or RESP): the in-flight request is dropped with no response. mem_memWrite falls immediately; no partial write may be extended.

## Test plan
- Word store then load:
  - store 0xDEADBEEF to addr 0x10 → mem_address = 4, mem_memWrite pulsed 1 cycle, resp at +2.
  - load word from 0x10 → resp_rdata = 0xDEADBEEF, resp_error = 0, resp at +2.
- Byte store RMW: word 4 = 0x11223344; sb 0xAA to addr 0x12 → one RD cycle, then WR with mem_writeData = 0x11AA3344; resp at +3.
- Sub-word loads with word 4 = 0x80F07F01:
  - lb addr 0x11 → 0x0000007F;
  - lb addr 0x13 → 0xFFFFFF80;
  - lbu addr 0x13 → 0x00000080;
  - lh addr 0x12 → 0xFFFF80F0;
  - lhu addr 0x12 → 0x000080F0.
- Errors: lw at 0x11, sh at 0x13, size 11 at 0x10 → each gives resp_error = 1 and resp_rdata = 0 at +1; mem_memRead and mem_memWrite never assert.
- Response backpressure: hold resp_ready = 0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready = 0 throughout, and a competing req_valid is not captured.
- Async reset: assert rst_n = 0 mid-cycle during WR → mem_memWrite = 0 before the next edge, the memory word is unchanged for a byte store caught in RD, no resp_valid appears, and req_ready = 1 after release.
